// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b-bin, LSB first, one full-subtractor cell and a borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q, res_d;
    logic             br_q, bout_q, ai, bi, d, br_d, last, accept;
    always_comb begin
        ai     = a_sh_q[0];
        bi     = b_sh_q[0];
        d      = ai ^ bi ^ br_q;
        br_d   = (~ai & bi) | (~(ai ^ bi) & br_q);
        res_d  = {d, res_q[WIDTH-1:1]};
        last   = cnt_q == CW'(WIDTH - 1);
        accept = (state_q == IDLE) && bus.start;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (bus.start ? RUN : IDLE) :
                  (state_q == RUN)  ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        bus.busy = state_q == RUN;
        bus.done = state_q == DONE;
        bus.diff = diff_q;
        bus.bout = bout_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
            br_q   <= bus.bin;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            res_q  <= res_d;
            br_q   <= br_d;
            cnt_q  <= cnt_q + 1'b1;
            if (last) begin
                diff_q <= res_d;
                bout_q <= br_d;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboarded random and directed check of serial_subtractor
module tb_serial_subtractor;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    serial_subtractor_if #(.WIDTH(W)) bus();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    exp_t         sb[$];
    int           checks = 0, fails = 0, cyc = 0, next_free = 0, last_acc = -100;
    int           n_acc = 0, n_done = 0;
    logic [W-1:0] held_d = '0;
    logic         held_b = 1'b0, prev_done = 1'b0;
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Reference: an op is accepted whenever start is seen and the unit is free; it occupies W+2 cycles.
    always @(posedge clk) begin
        logic [W:0] r;
        cyc++;
        if (!rst && bus.start && cyc >= next_free) begin
            r = {1'b0, bus.a} - {1'b0, bus.b} - (W+1)'(bus.bin);
            sb.push_back('{r[W-1:0], r[W], cyc});
            last_acc  = cyc;
            next_free = cyc + W + 2;
            n_acc++;
        end
    end
    always @(posedge rst) begin
        sb.delete();
        last_acc  = -100;
        next_free = 0;
        held_d    = '0;
        held_b    = 1'b0;
    end
    always @(negedge clk) begin
        exp_t e;
        chk("busy", int'(bus.busy), int'(cyc - last_acc < W));
        chk("done", int'(bus.done), int'(cyc - last_acc == W));
        chk("done_twice", int'(prev_done && bus.done), 0);
        if (bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_done: got done=1, expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("diff", int'(bus.diff), int'(e.d));
                chk("bout", int'(bus.bout), int'(e.bo));
                chk("latency", cyc - e.acc, W);
                held_d = e.d;
                held_b = e.bo;
            end
        end
        chk("diff_hold", int'(bus.diff), int'(held_d));
        chk("bout_hold", int'(bus.bout), int'(held_b));
        prev_done = bus.done;
    end
    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL timeout: got %0d pending ops, expected 0", sb.size());
            sb.delete();
        end
    endtask
    task automatic op(logic [W-1:0] a, logic [W-1:0] b, logic bin);
        for (int i = 0; i < 40 && cyc + 1 < next_free; i++) @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
    endtask
    initial begin
        int d0, target;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_bout", int'(bus.bout), 0);
        rst = 1'b0;
        @(negedge clk);
        op(8'h5A, 8'h23, 1'b0);
        op(8'h10, 8'h20, 1'b0);
        op(8'h00, 8'h00, 1'b1);
        op(8'hFF, 8'hFF, 1'b0);
        op(8'hFF, 8'h00, 1'b1);
        op(8'hFF, 8'h00, 1'b0);
        op(8'h42, 8'h42, 1'b0);
        d0 = n_done;
        bus.a = 8'h80; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.a = 8'h00; bus.b = 8'h00; bus.bin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'h55; bus.bin = 1'b0;
        @(negedge clk);
        bus.a = 8'h03; bus.b = 8'hC0; bus.bin = 1'b1; bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("single_done", n_done - d0, 1);
        bus.a = 8'h33; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_diff", int'(bus.diff), 0);
        chk("arst_bout", int'(bus.bout), 0);
        @(negedge clk);
        rst = 1'b0;
        op(8'h09, 8'h04, 1'b0);
        chk("post_rst_diff", int'(bus.diff), 8'h05);
        target    = n_acc + 200;
        bus.start = 1'b1;
        for (int i = 0; i < 3000 && n_acc < target; i++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.bin = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("random_ops_accepted", n_acc, target);
        drain();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
